// File: rtl/iig_ctrl.sv
// Raster sequencer for the integral-image datapath: pixel handshake,
// MAC / BUF0 strobes and a two-stage token pipeline to the sum register.
module iig_ctrl #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 32,
    parameter int XW    = 6,
    parameter int YW    = 5
) (
    input  logic          iClk,
    input  logic          iReset_n,
    input  logic          iStart,
    input  logic          iPix_valid,
    output logic          oPix_ready,
    output logic          oMac_load,
    output logic          oMac_acc,
    output logic [XW-1:0] oBuf_rd_addr,
    output logic          oSum_en,
    output logic          oBuf_wr_en,
    output logic [XW-1:0] oBuf_wr_addr,
    output logic          oOut_valid,
    output logic [XW-1:0] oOut_x,
    output logic [YW-1:0] oOut_y,
    output logic          oBusy,
    output logic          oDone
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } state_t;

    localparam logic [XW-1:0] XLAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] YLAST = YW'(IMG_H - 1);

    state_t        state;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          flushCnt;
    logic          accept;

    logic          v1;
    logic [XW-1:0] x1;
    logic [YW-1:0] y1;

    assign accept       = iPix_valid & oPix_ready;
    assign oMac_load    = accept & (x == '0);
    assign oMac_acc     = accept & (x != '0);
    assign oBuf_rd_addr = x;

    always_ff @(posedge iClk) begin
        if (!iReset_n) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            flushCnt   <= 1'b0;
            oPix_ready <= 1'b0;
            oBusy      <= 1'b0;
            oDone      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    oDone <= 1'b0;
                    if (iStart) begin
                        state      <= RUN;
                        x          <= '0;
                        y          <= '0;
                        oPix_ready <= 1'b1;
                        oBusy      <= 1'b1;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (x == XLAST) begin
                            x <= '0;
                            if (y == YLAST) begin
                                y          <= '0;
                                state      <= FLUSH;
                                flushCnt   <= 1'b0;
                                oPix_ready <= 1'b0;
                            end else begin
                                y <= y + YW'(1);
                            end
                        end else begin
                            x <= x + XW'(1);
                        end
                    end
                end
                FLUSH: begin
                    // Two drain cycles let the last token reach the BUF0 write.
                    if (flushCnt) begin
                        state <= DONE;
                        oBusy <= 1'b0;
                        oDone <= 1'b1;
                    end else begin
                        flushCnt <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    oDone <= 1'b0;
                end
            endcase
        end
    end

    // Tokens carry their own coordinates; bubbles travel as v=0.
    always_ff @(posedge iClk) begin
        if (!iReset_n) begin
            v1           <= 1'b0;
            x1           <= '0;
            y1           <= '0;
            oSum_en      <= 1'b0;
            oOut_valid   <= 1'b0;
            oBuf_wr_en   <= 1'b0;
            oOut_x       <= '0;
            oOut_y       <= '0;
            oBuf_wr_addr <= '0;
        end else begin
            v1           <= accept;
            x1           <= x;
            y1           <= y;
            oSum_en      <= accept & (y != '0);
            oOut_valid   <= v1;
            oBuf_wr_en   <= v1;
            oOut_x       <= x1;
            oOut_y       <= y1;
            oBuf_wr_addr <= x1;
        end
    end

endmodule
